if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//   Parametrised fetch stage: PC register plus next-PC select (sequential / branch / jump).
//   Issues requests to a variable-latency instruction memory.
//   Buffers returned instructions in a DEPTH-entry queue feeding decode via valid/ready.
//   Sits between pc/IMEM and the IF/ID boundary. A taken redirect flushes all queued and in-flight fetches.
// PARAMETERS
//   WIDTH     32  PC / instruction width (bits)
//   DEPTH     4   queue entries; power of 2, >= 2
//   RESET_PC  0   PC value after reset
//   PC_INC    4   sequential PC increment
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous, active-low reset
//   stall_pc     in   1      1 = block new fetch issue (redirects still honoured)
//   jump         in   1      redirect to pc_jump (priority over pcsrc)
//   pc_jump      in   WIDTH  jump target
//   pcsrc        in   1      redirect to pc_branch
//   pc_branch    in   WIDTH  branch target
//   imem_req     out  1      fetch request; address accepted the same cycle
//   imem_addr    out  WIDTH  fetch address (= current PC)
//   imem_rvalid  in   1      response valid, >= 1 cycle after req
//   imem_rdata   in   WIDTH  response instruction
//   instr_valid  out  1      queue head valid to decode
//   instr_ready  in   1      decode accepts head
//   instr        out  WIDTH  head instruction
//   pc_fetch     out  WIDTH  head instruction address + PC_INC
//   q_count      out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//   Reset (rst=0, async): pc=RESET_PC, q_count=0, outstanding=0, drop=0, instr_valid=0, imem_req=0.
//   redirect = jump | pcsrc; target = jump ? pc_jump : pc_branch.
//   Issue
//   - At most one outstanding request.
//   - imem_req = !stall_pc & !redirect & (!outstanding | accepted rvalid this cycle) & next_count < DEPTH.
//     next_count = q_count + push - pop, evaluated in the same cycle.
//   - On issue: outstanding<=1; pc<=pc+PC_INC, wraps modulo 2^WIDTH.
//   Response: imem_rvalid with outstanding=1 clears outstanding.
//   - drop=0: push {rdata, addr+PC_INC} at the tail.
//   - drop=1: discard the response and clear drop.
//   - rvalid with outstanding=0 is ignored.
//   Pop: instr_valid & instr_ready removes the head.
//   - Simultaneous push and pop: count unchanged.
//   - Full queue never overflows; issue reservation guarantees a free slot.
//   Redirect (takes effect at the clock edge, even when stall_pc=1)
//   - pc<=target; queue cleared (q_count=0, instr_valid=0 next cycle).
//   - Same-cycle push and pop are discarded.
//   - If outstanding and no rvalid this cycle: drop<=1, and the stale response is discarded later.
//   - No issue in the redirect cycle; fetch from target may issue the next cycle.
//   Throughput: with 1-cycle memory latency and instr_ready=1, one instruction per cycle.
//   stall_pc does not stop pops or response pushes.
//   Pointers: rd/wr wrap modulo DEPTH; full = (q_count==DEPTH), empty = (q_count==0).
// CONFIGURATION
//   IFQ_BYPASS_EN defined
//   - When the queue is empty and an accepted, non-dropped rvalid arrives, instr_valid=1 that cycle.
//   - instr/pc_fetch are driven combinationally from imem_rdata / addr+PC_INC.
//   - If instr_ready=1 the entry is consumed and not written; otherwise it is pushed.
//   IFQ_BYPASS_EN undefined
//   - Outputs come only from the queue head.
//   - Response-to-instr_valid latency is >= 1 cycle.
// TESTING
//   1 Reset with RESET_PC=0x100 -> imem_addr=0x100, instr_valid=0, q_count=0; first req the cycle after rst rises.
//   2 1-cycle memory, instr_ready=1, 8 instrs -> addrs 0x100..0x11C in order;
//     pc_fetch=addr+4; one instr per cycle after fill.
//   3 instr_ready=0 with DEPTH=4 -> exactly 4 pushed, imem_req held 0, q_count=4;
//     release ready -> 4 pops, fetch resumes.
//   4 pcsrc=1 with pc_branch=0x200 while a response is outstanding (3-cycle latency) and q_count=2
//     -> queue empty next cycle, stale rdata dropped, next delivered instr from 0x200.
//   5 jump=1 and pcsrc=1 in the same cycle (pc_jump=0x300, pc_branch=0x200) -> next fetch 0x300;
//     redirect with stall_pc=1 -> pc updated, no req until stall_pc=0.
//   6 rst asserted mid-stream with q_count=3 -> all outputs reset immediately;
//     with IFQ_BYPASS_EN, empty queue plus ready -> instr valid in the same cycle as rvalid.

Source files
------------

// File: rtl/if_fetch_queue.sv
// -----------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction fetch stage. Holds the PC, picks the next PC (sequential, branch
// or jump), issues one request at a time to a variable-latency instruction
// memory and buffers the returned instructions in a DEPTH-entry queue. Decode
// drains the queue through a valid/ready handshake. A taken redirect (jump or
// branch) flushes everything queued and marks any in-flight fetch as stale.
//
// Parameters
//   WIDTH     PC / instruction width in bits
//   DEPTH     queue entries (power of 2, >= 2)
//   RESET_PC  PC value after reset
//   PC_INC    sequential PC increment
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   stall_pc     in   blocks new fetch issue; redirects are still honoured
//   jump         in   redirect to pc_jump (wins over pcsrc)
//   pc_jump      in   jump target
//   pcsrc        in   redirect to pc_branch
//   pc_branch    in   branch target
//   imem_req     out  fetch request, address accepted in the same cycle
//   imem_addr    out  fetch address (current PC)
//   imem_rvalid  in   response valid, at least one cycle after the request
//   imem_rdata   in   response instruction
//   instr_valid  out  queue head valid towards decode
//   instr_ready  in   decode accepts the head
//   instr        out  head instruction
//   pc_fetch     out  head instruction address + PC_INC
//   q_count      out  number of occupied queue entries
//
// Configuration
//   IFQ_BYPASS_EN  when defined, a response arriving at an empty queue is
//                  presented to decode in the same cycle (and is only written
//                  into the queue if decode does not take it). When undefined,
//                  decode only ever sees the queue head.
// -----------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      PC_INC   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_pc,
    input  logic                    jump,
    input  logic [WIDTH-1:0]        pc_jump,
    input  logic                    pcsrc,
    input  logic [WIDTH-1:0]        pc_branch,
    output logic                    imem_req,
    output logic [WIDTH-1:0]        imem_addr,
    input  logic                    imem_rvalid,
    input  logic [WIDTH-1:0]        imem_rdata,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [WIDTH-1:0]        instr,
    output logic [WIDTH-1:0]        pc_fetch,
    output logic [$clog2(DEPTH):0]  q_count
);

    localparam int unsigned      PTR_W     = $clog2(DEPTH);
    localparam int unsigned      CNT_W     = PTR_W + 1;
    localparam logic [WIDTH-1:0] INC       = WIDTH'(PC_INC);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    // Request tracker: nothing in flight, one live request in flight, or one
    // stale request in flight whose response must be thrown away.
    typedef enum logic [1:0] {
        FS_IDLE,
        FS_BUSY,
        FS_DROP
    } fetch_state_e;

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] req_addr_q, req_addr_d;  // address of the request in flight
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             run_q;                   // low for the first cycle out of reset

    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pcf_mem_q   [DEPTH];

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             outstanding;
    logic             resp_accept;
    logic             resp_keep;
    logic [WIDTH-1:0] resp_pc;
    logic             q_empty;
    logic             bypass;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] next_count;

    // -------------------------------------------------------------------------
    // Redirect and response qualification
    // -------------------------------------------------------------------------
    assign redirect    = jump | pcsrc;
    assign target      = jump ? pc_jump : pc_branch;

    assign outstanding = (state_q != FS_IDLE);
    // A response is only meaningful while a request is in flight.
    assign resp_accept = imem_rvalid & outstanding;
    // Stale responses and responses landing in a redirect cycle are discarded.
    assign resp_keep   = resp_accept & (state_q == FS_BUSY) & ~redirect;
    assign resp_pc     = req_addr_q + INC;

    assign q_empty     = (count_q == '0);

    // -------------------------------------------------------------------------
    // Decode-side outputs
    // -------------------------------------------------------------------------
`ifdef IFQ_BYPASS_EN
    assign bypass   = resp_keep & q_empty;
    assign instr    = bypass ? imem_rdata : instr_mem_q[rd_ptr_q];
    assign pc_fetch = bypass ? resp_pc    : pcf_mem_q[rd_ptr_q];
`else
    assign bypass   = 1'b0;
    assign instr    = instr_mem_q[rd_ptr_q];
    assign pc_fetch = pcf_mem_q[rd_ptr_q];
`endif

    assign instr_valid = ~q_empty | bypass;

    // A bypassed response taken by decode never touches the queue.
    assign push = resp_keep & ~(bypass & instr_ready);
    // A pop in a redirect cycle is moot: the whole queue is cleared anyway.
    assign pop  = ~q_empty & instr_ready & ~redirect;

    assign next_count = count_q + CNT_W'(push) - CNT_W'(pop);

    // -------------------------------------------------------------------------
    // Fetch issue
    // -------------------------------------------------------------------------
    // Only one request may be in flight; a response accepted this cycle frees
    // the slot immediately so back-to-back fetches sustain one per cycle.
    // Requiring next_count < DEPTH reserves a queue slot for the response, so
    // the queue can never overflow.
    assign imem_req  = run_q & ~stall_pc & ~redirect
                     & (~outstanding | resp_accept)
                     & (next_count < CNT_DEPTH);
    assign imem_addr = pc_q;
    assign q_count   = count_q;

    // -------------------------------------------------------------------------
    // Request tracker next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        if (imem_req) begin
            state_d = FS_BUSY;
        end else if (resp_accept) begin
            state_d = FS_IDLE;
        end else if (redirect && state_q == FS_BUSY) begin
            // Response still on its way: remember to throw it away.
            state_d = FS_DROP;
        end
    end

    // -------------------------------------------------------------------------
    // PC, pointer and count next state
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        count_d    = next_count;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);   // wraps modulo DEPTH
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        if (redirect) begin
            pc_d     = target;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else if (imem_req) begin
            pc_d       = pc_q + INC;            // wraps modulo 2^WIDTH
            req_addr_d = pc_q;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            run_q      <= 1'b1;
        end
    end

    // NOTE: the queue storage is deliberately not reset; count_q alone says
    // which entries hold data, and an unreset array maps onto plain storage.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pcf_mem_q[wr_ptr_q]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h100;
    localparam logic [31:0] INC = 32'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_pc = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] pc_jump = '0;
    logic        pcsrc = 1'b0;
    logic [31:0] pc_branch = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc_fetch;
    logic [2:0]  q_count;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .WIDTH    (32),
        .DEPTH    (D),
        .RESET_PC (RPC),
        .PC_INC   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_pc    (stall_pc),
        .jump        (jump),
        .pc_jump     (pc_jump),
        .pcsrc       (pcsrc),
        .pc_branch   (pc_branch),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc_fetch    (pc_fetch),
        .q_count     (q_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction word the memory returns for a given address.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // ---------------------------------------------------------------------
    // Reference model: expected decode stream plus memory/PC bookkeeping
    // ---------------------------------------------------------------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] pcf;
    } entry_t;

    entry_t      mq[$];          // instructions decode should still receive
    logic [31:0] delivered[$];   // pc_fetch of every accepted instruction
    logic [31:0] pc_model;
    bit          armed;
    bit          has_pending;
    logic [31:0] pend_addr;
    int          pend_epoch;
    int          pend_wait;
    int          epoch;
    bit          resp_now, kept_now, redirect_now, req_seen, checking;
    logic [31:0] redirect_target;
    int          pops_seen, reqs_seen;

    // Stimulus knobs (percentages / latency range / one-shot forces)
    int          p_ready, p_stall, p_redir, p_spur, lat_min, lat_max;
    bit          force_jump, force_pcsrc, force_stall;
    logic [31:0] f_jump, f_branch;

    // ---------------------------------------------------------------------
    // One clock cycle of stimulus: account for the edge just passed, then
    // drive this cycle's inputs and memory response.
    // ---------------------------------------------------------------------
    task automatic step();
        int r;
        @(posedge clk);
        #1;
        armed = 1'b1;
        if (resp_now) has_pending = 1'b0;
        if (redirect_now) begin
            mq.delete();
            epoch++;
            pc_model = redirect_target;
        end
        if (req_seen) begin
            has_pending = 1'b1;
            pend_addr   = pc_model;
            pend_epoch  = epoch;
            pend_wait   = $urandom_range(lat_max, lat_min) - 1;
            pc_model    = pc_model + INC;
        end else if (has_pending && pend_wait > 0) begin
            pend_wait--;
        end

        jump      = 1'b0;
        pcsrc     = 1'b0;
        pc_jump   = $urandom & 32'hFFFF_FFFC;
        pc_branch = $urandom & 32'hFFFF_FFFC;
        if (force_jump || force_pcsrc) begin
            jump        = force_jump;
            pcsrc       = force_pcsrc;
            pc_jump     = f_jump;
            pc_branch   = f_branch;
            force_jump  = 1'b0;
            force_pcsrc = 1'b0;
        end else if (int'($urandom_range(99)) < p_redir) begin
            r     = $urandom_range(2);
            jump  = (r != 1);
            pcsrc = (r != 0);
        end
        redirect_now    = jump | pcsrc;
        redirect_target = jump ? pc_jump : pc_branch;

        stall_pc    = force_stall || (int'($urandom_range(99)) < p_stall);
        instr_ready = int'($urandom_range(99)) < p_ready;

        resp_now = has_pending && pend_wait == 0;
        kept_now = 1'b0;
        if (resp_now) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(pend_addr);
            kept_now    = (pend_epoch == epoch) && !redirect_now;
        end else begin
            // Spurious responses only while nothing is in flight.
            imem_rvalid = !has_pending && (int'($urandom_range(99)) < p_spur);
            imem_rdata  = $urandom;
        end
        if (kept_now) mq.push_back('{ins: instr_of(pend_addr), pcf: pend_addr + INC});
    endtask

    // ---------------------------------------------------------------------
    // Monitor: compares DUT outputs against the model on every falling edge
    // ---------------------------------------------------------------------
    int exp_cnt;
    bit exp_valid, exp_req;

    always @(negedge clk) begin
        if (checking) begin
            exp_cnt = mq.size() - int'(kept_now);
            check("q_count", 32'(q_count), exp_cnt);
`ifdef IFQ_BYPASS_EN
            exp_valid = mq.size() > 0;
`else
            exp_valid = exp_cnt > 0;
`endif
            check("instr_valid", 32'(instr_valid), 32'(exp_valid));
            if (instr_valid && exp_valid) begin
                check("instr", instr, mq[0].ins);
                check("pc_fetch", pc_fetch, mq[0].pcf);
                if (instr_ready && !redirect_now) begin
                    delivered.push_back(pc_fetch);
                    void'(mq.pop_front());
                    pops_seen++;
                end
            end
            exp_req = armed && !stall_pc && !redirect_now
                    && (!has_pending || resp_now) && (mq.size() < D);
            check("imem_req", 32'(imem_req), 32'(exp_req));
            check("imem_addr", imem_addr, pc_model);
            req_seen = imem_req;
            if (imem_req) reqs_seen++;
        end
    end

    task automatic do_reset();
        checking     = 1'b0;
        rst          = 1'b0;
        stall_pc     = 1'b0;
        jump         = 1'b0;
        pcsrc        = 1'b0;
        imem_rvalid  = 1'b0;
        instr_ready  = 1'b0;
        mq.delete();
        delivered.delete();
        has_pending  = 1'b0;
        resp_now     = 1'b0;
        kept_now     = 1'b0;
        redirect_now = 1'b0;
        req_seen     = 1'b0;
        armed        = 1'b0;
        pc_model     = RPC;
        repeat (2) @(posedge clk);
        #1;
        check("rst_imem_addr", imem_addr, RPC);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_q_count", 32'(q_count), 0);
        check("rst_imem_req", 32'(imem_req), 0);
        rst      = 1'b1;
        checking = 1'b1;
    endtask

    task automatic set_knobs(input int rdy, input int stl, input int rdr, input int spur,
                             input int lmin, input int lmax);
        p_ready = rdy; p_stall = stl; p_redir = rdr; p_spur = spur;
        lat_min = lmin; lat_max = lmax;
    endtask

    int  p0, r0;
    bit  found;

    initial begin
        epoch = 0; pops_seen = 0; reqs_seen = 0;
        force_jump = 0; force_pcsrc = 0; force_stall = 0;
        f_jump = '0; f_branch = '0;
        set_knobs(100, 0, 0, 0, 1, 1);

        // Reset and first request timing
        do_reset();
        @(negedge clk); #1;
        check("req_in_release_cycle", 32'(imem_req), 0);
        step();
        @(negedge clk); #1;
        check("first_req", 32'(imem_req), 1);
        check("first_addr", imem_addr, RPC);
        step();
        @(negedge clk); #1;
`ifdef IFQ_BYPASS_EN
        check("bypass_same_cycle_valid", 32'(instr_valid), 1);
`else
        check("no_bypass_valid_latency", 32'(instr_valid), 0);
`endif

        // Streaming with 1-cycle memory: in-order addresses, one per cycle
        for (int i = 0; i < 28; i++) begin
            step();
            if (i == 5) p0 = pops_seen;
        end
        @(negedge clk); #1;
        check("throughput_pops", pops_seen - p0, 23);
        for (int i = 0; i < 8; i++)
            check("stream_pc_fetch", delivered.size() > i ? delivered[i] : 32'hDEAD_BEEF,
                  RPC + INC * (i + 1));

        // Backpressure: queue fills to DEPTH, fetch stops, then drains
        p_ready = 0;
        repeat (12) step();
        @(negedge clk); #1;
        check("full_q_count", 32'(q_count), D);
        check("full_no_req", 32'(imem_req), 0);
        p_ready = 100;
        p0 = pops_seen; r0 = reqs_seen;
        repeat (4) step();
        @(negedge clk); #1;
        check("drain_pops", pops_seen - p0, 4);
        check("fetch_resumed", 32'(reqs_seen > r0), 1);

        // Branch while a 3-cycle fetch is in flight with two entries queued
        set_knobs(0, 0, 0, 0, 3, 3);
        repeat (8) step();
        p_ready = 100;
        repeat (8) step();
        p_ready = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            found = (mq.size() == 2) && has_pending && !resp_now && pend_wait >= 2;
        end
        check("branch_setup_found", 32'(found), 1);
        force_pcsrc = 1'b1; f_branch = 32'h200; f_jump = 32'h0;
        step();
        p_ready = 100;
        step();
        @(negedge clk); #1;
        check("branch_flush_count", 32'(q_count), 0);
        check("branch_flush_valid", 32'(instr_valid), 0);
        delivered.delete();
        repeat (20) step();
        check("branch_first_pc_fetch", delivered.size() > 0 ? delivered[0] : 32'hDEAD_BEEF,
              32'h204);

        // Jump and branch together: jump wins
        set_knobs(100, 0, 0, 0, 1, 1);
        repeat (6) step();
        force_jump = 1'b1; force_pcsrc = 1'b1; f_jump = 32'h300; f_branch = 32'h200;
        step();
        step();
        @(negedge clk); #1;
        check("jump_priority_req", 32'(imem_req), 1);
        check("jump_priority_addr", imem_addr, 32'h300);

        // Redirect under stall: PC moves, no request until stall drops
        repeat (4) step();
        force_stall = 1'b1; force_pcsrc = 1'b1; f_branch = 32'h480;
        step();
        repeat (3) begin
            step();
            @(negedge clk); #1;
            check("stall_redirect_addr", imem_addr, 32'h480);
            check("stall_redirect_no_req", 32'(imem_req), 0);
        end
        force_stall = 1'b0;
        step();
        @(negedge clk); #1;
        check("stall_release_req", 32'(imem_req), 1);
        check("stall_release_addr", imem_addr, 32'h480);

        // Randomised traffic
        set_knobs(70, 20, 8, 20, 1, 4);
        repeat (600) step();

        // Reset in the middle of a stream with three queued entries
        set_knobs(0, 0, 0, 0, 1, 1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            found = (mq.size() - int'(kept_now)) == 3;
        end
        check("midreset_setup_found", 32'(found), 1);
        check("midreset_q_count_before", 32'(q_count), 3);
        checking = 1'b0;
        rst = 1'b0;
        #1;
        check("midreset_instr_valid", 32'(instr_valid), 0);
        check("midreset_q_count", 32'(q_count), 0);
        check("midreset_imem_req", 32'(imem_req), 0);
        check("midreset_imem_addr", imem_addr, RPC);
        do_reset();
        set_knobs(70, 20, 8, 20, 1, 4);
        repeat (200) step();
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
